// File: rtl/inst_fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_stage_if : loader/fetch bundle for inst_fetch_stage
// Revision 1.0
// ---------------------------------------------------------------------------
interface inst_fetch_stage_if #(
  parameter int PC_W = 3
) ();
  logic            wr_en;
  logic [PC_W-1:0] wr_addr;
  logic [31:0]     wr_data;
  logic            start;
  logic            stall;
  logic [31:0]     inst32;
  logic            inst_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            busy;
  logic            done;
  logic [PC_W:0]   fetch_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, start, stall,
    input  inst32, inst_valid, fetch_pc, busy, done, fetch_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stall,
    output inst32, inst_valid, fetch_pc, busy, done, fetch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch_stage : walks PC 0..MAX_PC over a loadable instruction memory
// Optional FETCH_PC_WRAP_EN: free-running PC wrap instead of stopping in DONE
// Revision 1.0
// ---------------------------------------------------------------------------
module inst_fetch_stage #(
  parameter int PC_W   = 3,
  parameter int DEPTH  = 8,
  parameter int MAX_PC = 7
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  inst_fetch_stage_if.slave  bus
);

  localparam logic [1:0]      S_IDLE    = 2'b00;
  localparam logic [1:0]      S_RUN     = 2'b01;
  localparam logic [1:0]      S_DONE    = 2'b10;
  localparam logic [PC_W-1:0] C_LAST_PC = PC_W'(MAX_PC);
  localparam logic [PC_W-1:0] C_PC_ONE  = PC_W'(1);
  localparam logic [PC_W:0]   C_CNT_ONE = (PC_W+1)'(1);

  logic [31:0]     mem [DEPTH];

  logic [1:0]      state_q,      state_d;
  logic [PC_W-1:0] pc_q,         pc_d;
  logic [31:0]     inst32_q,     inst32_d;
  logic            inst_valid_q, inst_valid_d;
  logic [PC_W-1:0] fetch_pc_q,   fetch_pc_d;
  logic            busy_q,       busy_d;
  logic            done_q,       done_d;
  logic [PC_W:0]   fetch_cnt_q,  fetch_cnt_d;

  logic w_loadable;
  logic w_start_ok;
  logic w_fetch;
  logic w_last;

  assign w_loadable = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef FETCH_PC_WRAP_EN
  assign w_start_ok = bus.start && (w_loadable || (state_q == S_RUN));
`else
  assign w_start_ok = bus.start && w_loadable;
`endif
  // A restart in RUN (wrap build) takes priority over the fetch of that cycle.
  assign w_fetch    = (state_q == S_RUN) && !bus.stall && !w_start_ok;
  assign w_last     = (pc_q == C_LAST_PC);

  // Instruction memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (bus.wr_en && w_loadable) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      inst32_q     <= 32'h0;
      inst_valid_q <= 1'b0;
      fetch_pc_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst32_q     <= inst32_d;
      inst_valid_q <= inst_valid_d;
      fetch_pc_q   <= fetch_pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok) state_d = S_RUN;
      end
      S_RUN: begin
`ifndef FETCH_PC_WRAP_EN
        if (w_fetch && w_last) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (w_start_ok) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    inst32_d     = inst32_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    inst_valid_d = 1'b0;
    if (w_start_ok) begin
      pc_d        = '0;
      fetch_cnt_d = '0;
    end else if (w_fetch) begin
      inst32_d     = mem[pc_q];
      fetch_pc_d   = pc_q;
      inst_valid_d = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + C_CNT_ONE;
`ifdef FETCH_PC_WRAP_EN
      pc_d = w_last ? '0 : pc_q + C_PC_ONE;
`else
      if (!w_last) pc_d = pc_q + C_PC_ONE;
`endif
    end
    // Decoding the next state keeps busy/done aligned with the live state.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign bus.inst32     = inst32_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fetch_pc   = fetch_pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fetch_cnt  = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_fetch_stage : directed self-checking bench for inst_fetch_stage
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_inst_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   n_valid;

  inst_fetch_stage_if #(.PC_W(3)) bus ();

  inst_fetch_stage #(.PC_W(3), .DEPTH(8), .MAX_PC(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " inst32"},     bus.inst32,             32'h0);
    chk({tag, " inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, " fetch_pc"},   {29'd0, bus.fetch_pc},   32'd0);
    chk({tag, " busy"},       {31'd0, bus.busy},       32'd0);
    chk({tag, " done"},       {31'd0, bus.done},       32'd0);
    chk({tag, " fetch_cnt"},  {28'd0, bus.fetch_cnt},  32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    n_valid = 0;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // load mem[k] = 0x1820 + k
    for (int k = 0; k < 8; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(k);
      bus.wr_data = 32'h0000_1820 + 32'(k);
      tick();
    end
    bus.wr_en = 1'b0;

`ifdef FETCH_PC_WRAP_EN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("wrap fetch_pc", {29'd0, bus.fetch_pc}, 32'(k % 8));
      chk("wrap done",     {31'd0, bus.done},     32'd0);
    end
    chk("wrap fetch_cnt", {28'd0, bus.fetch_cnt}, 32'd10);
`else
    // stall-free run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start busy",  {31'd0, bus.busy},       32'd1);
    chk("start valid", {31'd0, bus.inst_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("run valid",     {31'd0, bus.inst_valid}, 32'd1);
      chk("run fetch_pc",  {29'd0, bus.fetch_pc},   32'(k));
      chk("run inst32",    bus.inst32,              32'h0000_1820 + 32'(k));
      chk("run fetch_cnt", {28'd0, bus.fetch_cnt},  32'(k + 1));
    end
    tick();
    chk("end valid",     {31'd0, bus.inst_valid}, 32'd0);
    chk("end done",      {31'd0, bus.done},       32'd1);
    chk("end busy",      {31'd0, bus.busy},       32'd0);
    chk("end fetch_cnt", {28'd0, bus.fetch_cnt},  32'd8);
    chk("end inst32",    bus.inst32,              32'h0000_1827);
    chk("end fetch_pc",  {29'd0, bus.fetch_pc},   32'd7);

    // stall for 3 cycles with pc at 3
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.inst_valid) n_valid++;
    end
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall valid",     {31'd0, bus.inst_valid}, 32'd0);
      chk("stall inst32",    bus.inst32,              32'h0000_1822);
      chk("stall fetch_pc",  {29'd0, bus.fetch_pc},   32'd2);
      chk("stall fetch_cnt", {28'd0, bus.fetch_cnt},  32'd3);
    end
    bus.stall = 1'b0;
    tick();
    chk("resume fetch_pc", {29'd0, bus.fetch_pc}, 32'd3);
    chk("resume inst32",   bus.inst32,            32'h0000_1823);
    if (bus.inst_valid) n_valid++;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.inst_valid) n_valid++;
    end
    chk("stall total valid", 32'(n_valid), 32'd8);
    chk("stall done",        {31'd0, bus.done}, 32'd1);

    // write + start in the same cycle from DONE
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 32'h0800_0004;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    // write attempt during RUN must be ignored
    bus.wr_addr = 3'd5;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    chk("wr+start inst32", bus.inst32, 32'h0800_0004);
    tick();
    bus.wr_en = 1'b0;
    for (int k = 2; k < 6; k++) tick();
    chk("run-write fetch_pc", {29'd0, bus.fetch_pc}, 32'd5);
    chk("run-write inst32",   bus.inst32,            32'h0000_1825);
    tick();
    tick();
    tick();
    chk("run-write done", {31'd0, bus.done}, 32'd1);

    // asynchronous reset between edges with pc at 4
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre-reset fetch_pc", {29'd0, bus.fetch_pc}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset idle busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("post-reset fetch_pc", {29'd0, bus.fetch_pc}, 32'd0);
    chk("post-reset inst32",   bus.inst32,            32'h0800_0004);
    tick();
    chk("post-reset inst32 1", bus.inst32,            32'h0000_1821);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction-type/destination-register counter stage.
- Holds a small instruction memory that the bench or loader fills word by word.
- On start, it walks the PC from 0 to MAX_PC and presents one 32-bit MIPS instruction per cycle on inst32, with a valid strobe.
- Supports stall, stops in a DONE state, and reports fetched PC and issue count.

Parameters:
- PC_W, 3, PC / memory address width.
- DEPTH, 8, number of instruction words; must equal 2**PC_W.
- MAX_PC, 7, last PC fetched before DONE; must be less than or equal to DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  instruction memory write enable; honoured only in IDLE and DONE.
- wr_addr  in  PC_W  write address.
- wr_data  in  32  instruction word to write.
- start  in  1  begin fetch from PC 0; honoured in IDLE and DONE.
- stall  in  1  downstream not ready; freeze fetch.
- inst32  out  32  registered fetched instruction.
- inst_valid  out  1  inst32 is a newly fetched word this cycle.
- fetch_pc  out  PC_W  PC that inst32 was fetched from.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- fetch_cnt  out  PC_W+1  number of instructions issued since last start.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-RUN):
  - State IDLE, pc=0.
  - inst32=32'h0, inst_valid=0, fetch_pc=0, busy=0, done=0, fetch_cnt=0.
  - Memory contents are not reset.
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and goes to IDLE on the next edge.
- IDLE:
  - wr_en=1 writes mem[wr_addr]<=wr_data at the edge.
  - start=1 sets pc<=0, fetch_cnt<=0, state<=RUN.
  - inst_valid=0.
- Write and start in the same cycle: the write lands at that edge, and the first fetch (next edge) returns the new word.
- RUN, stall=0, at each edge:
  - inst32<=mem[pc], fetch_pc<=pc, inst_valid<=1, fetch_cnt<=fetch_cnt+1.
  - If pc==MAX_PC, state<=DONE; otherwise pc<=pc+1.
- RUN, stall=1: pc, inst32, fetch_pc and fetch_cnt hold; inst_valid<=0. Stall is sampled at the edge; there is no skid.
- RUN ignores wr_en and start.
- Latency: start sampled at edge N gives the first inst_valid=1 after edge N+1. A stall-free run gives MAX_PC+1 consecutive valid cycles.
- DONE:
  - done=1, inst_valid=0; inst32/fetch_pc hold the last word; fetch_cnt holds MAX_PC+1.
  - wr_en is accepted as in IDLE.
  - start re-arms: pc<=0, fetch_cnt<=0, done<=0, state<=RUN.
- busy and done are registered and decoded from the state.
- Arithmetic: pc increments modulo 2**PC_W. fetch_cnt is PC_W+1 bits, so MAX_PC+1 fits without overflow.

Optional Feature:
- Macro: FETCH_PC_WRAP_EN.
- Defined:
  - At pc==MAX_PC with stall=0, pc<=0 and the state stays RUN. DONE is never entered; done stays 0.
  - fetch_cnt wraps modulo 2**(PC_W+1).
  - start while in RUN restarts at pc 0 with fetch_cnt cleared.
  - Stall behaviour is unchanged.
- Undefined: the behaviour above; the block stops in DONE after MAX_PC.

Test Plan:
- Load mem[k]=32'h0000_1820+k for k=0..7, pulse start, no stall -> 8 consecutive inst_valid cycles; fetch_pc 0..7; inst32 matches; then done=1, busy=0, fetch_cnt=8.
- Mid-run, stall=1 for 3 cycles at pc 3 -> inst_valid=0 for 3 cycles, inst32/fetch_pc hold word 2, then resume with pc 3; total valid count is still 8.
- wr_en with wr_addr=0, wr_data=32'h0800_0004 in the same cycle as start -> first inst32=32'h0800_0004.
- wr_en during RUN at addr 5 -> ignored; fetch 5 returns the original word.
- rst_n=0 asserted between edges while pc=4 -> all outputs zero immediately; state IDLE; after release, start refetches from pc 0 with memory retained.
- With FETCH_PC_WRAP_EN, 10 stall-free cycles -> fetch_pc sequence 0..7,0,1; done=0; fetch_cnt=10.
